hdmi_data_island_decoder: RTL and testbench

- Receive-side counterpart of the HDMI data-island packet encoder; sits after the TERC4 symbol decoder in the HDMI capture path.
- Takes per-pixel 4-bit data-island nibbles for channels 0/1/2 and reassembles 32-cycle packets (24-bit header + four 56-bit subpackets).
- Checks the BCH parity of every packet and exports the raw header.
- Decodes Audio Clock Regeneration (N/CTS) and Audio Sample packets into a 16-bit stereo sample stream.

---
 rtl/hdmi_data_island_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_hdmi_data_island_decoder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_data_island_decoder.sv
// HDMI data-island receive path: reframes TERC4 nibbles into 32-cycle packets,
// checks BCH parity, and extracts ACR (N/CTS) and 2-channel audio samples.
module hdmi_data_island_decoder #(
  parameter int MAX_PACKETS  = 18,
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic        i_pixclk,
  input  logic        i_reset,
  input  logic        i_data,
  input  logic [3:0]  i_d0,
  input  logic [3:0]  i_d1,
  input  logic [3:0]  i_d2,
  output logic        o_hSync,
  output logic        o_vSync,
  output logic        o_pkt_valid,
  output logic [23:0] o_pkt_hdr,
  output logic        o_hdr_ecc_ok,
  output logic [3:0]  o_sp_ecc_ok,
  output logic        o_acr_valid,
  output logic [19:0] o_n,
  output logic [19:0] o_cts,
  output logic        o_audio_valid,
  output logic [15:0] o_audioL,
  output logic [15:0] o_audioR,
  output logic        o_block_start,
  output logic [1:0]  o_cs_bit,
  output logic        o_parity_err
);

  localparam int IDXW = $clog2(MAX_PACKETS + 1);

  function automatic logic [7:0] bchStep(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'hC1 : 8'h00);
  endfunction

  logic [4:0]      cycCnt;
  logic [IDXW-1:0] pktIdx;
  logic            accepting;
  logic            first;
  logic            latch;

  logic [23:0] hdrSr, hdrSrNxt;
  logic [7:0]  hdrC, hdrCNxt, hdrCBase;
  logic        hdrOk, hdrOkNxt;
  logic [55:0] spSr [4];
  logic [55:0] spSrNxt [4];
  logic [7:0]  spC [4];
  logic [7:0]  spCNxt [4];
  logic [7:0]  spCBase [4];
  logic [3:0]  spOk, spOkNxt;

  assign accepting = (pktIdx != IDXW'(MAX_PACKETS));
  assign first     = (cycCnt == 5'd0);
  assign latch     = i_data && accepting && (cycCnt == 5'd31);
  assign hdrCBase  = first ? 8'h00 : hdrC;

  // Cycle 0 restarts every code: the LFSR base is zero and the ok flag is re-armed.
  always_comb begin
    hdrSrNxt = hdrSr;
    hdrCNxt  = {hdrCBase[6:0], 1'b0};
    hdrOkNxt = first | hdrOk;
    if (cycCnt < 5'd24) begin
      hdrSrNxt = {i_d0[2], hdrSr[23:1]};
      hdrCNxt  = bchStep(hdrCBase, i_d0[2]);
    end else if (i_d0[2] != hdrCBase[7]) begin
      hdrOkNxt = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      spCBase[k] = first ? 8'h00 : spC[k];
      spSrNxt[k] = spSr[k];
      spCNxt[k]  = {spCBase[k][5:0], 2'b00};
      spOkNxt[k] = first | spOk[k];
      if (cycCnt < 5'd28) begin
        spSrNxt[k] = {i_d2[k], i_d1[k], spSr[k][55:2]};
        spCNxt[k]  = bchStep(bchStep(spCBase[k], i_d1[k]), i_d2[k]);
      end else if ((i_d1[k] != spCBase[k][7]) || (i_d2[k] != spCBase[k][6])) begin
        spOkNxt[k] = 1'b0;
      end
    end
  end

  // Packet-type decode on the fully assembled packet (valid while latch is high).
  logic        isAcr, isAudio;
  logic [3:0]  cand, parBad, keepMask;
  logic [15:0] newL [4];
  logic [15:0] newR [4];
  logic [1:0]  newCs [4];

  assign isAcr   = (hdrSr[7:0] == 8'h01) && hdrOkNxt && spOkNxt[0];
  assign isAudio = (hdrSr[7:0] == 8'h02) && hdrOkNxt;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      newL[k]     = spSr[k][23:8];
      newR[k]     = spSr[k][47:32];
      newCs[k]    = {spSr[k][54], spSr[k][50]};
      cand[k]     = isAudio && hdrSr[8+k] && spOkNxt[k];
      parBad[k]   = (^spSr[k][27:0]) | (^{spSr[k][51:48], spSr[k][47:24]});
      keepMask[k] = cand[k] && (!CHECK_PARITY || !parBad[k]);
    end
  end

  // Sample emission: first sample goes out with the packet pulse, the rest from hold registers.
  logic [15:0] holdL [4];
  logic [15:0] holdR [4];
  logic [1:0]  holdCs [4];
  logic [3:0]  holdB;
  logic [3:0]  pendMask, srcMask, selBit;
  logic [1:0]  selIdx;
  logic        selHit;
  logic [15:0] srcL, srcR;
  logic [1:0]  srcCs;
  logic        srcB;

  always_comb begin
    srcMask = latch ? keepMask : pendMask;
    selIdx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (srcMask[k]) selIdx = 2'(k);
    end
    selHit = |srcMask;
    selBit = selHit ? (4'b0001 << selIdx) : 4'b0000;
    srcL   = latch ? newL[selIdx]  : holdL[selIdx];
    srcR   = latch ? newR[selIdx]  : holdR[selIdx];
    srcCs  = latch ? newCs[selIdx] : holdCs[selIdx];
    srcB   = latch ? hdrSr[20 + 32'(selIdx)] : holdB[selIdx];
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      cycCnt        <= '0;
      pktIdx        <= '0;
      hdrSr         <= '0;
      hdrC          <= '0;
      hdrOk         <= 1'b0;
      spOk          <= '0;
      holdB         <= '0;
      pendMask      <= '0;
      o_hSync       <= 1'b0;
      o_vSync       <= 1'b0;
      o_pkt_valid   <= 1'b0;
      o_pkt_hdr     <= '0;
      o_hdr_ecc_ok  <= 1'b0;
      o_sp_ecc_ok   <= '0;
      o_acr_valid   <= 1'b0;
      o_n           <= '0;
      o_cts         <= '0;
      o_audio_valid <= 1'b0;
      o_audioL      <= '0;
      o_audioR      <= '0;
      o_block_start <= 1'b0;
      o_cs_bit      <= '0;
      o_parity_err  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        spSr[k]   <= '0;
        spC[k]    <= '0;
        holdL[k]  <= '0;
        holdR[k]  <= '0;
        holdCs[k] <= '0;
      end
    end else begin
      if (!i_data) begin
        cycCnt <= '0;
        pktIdx <= '0;
      end else begin
        cycCnt  <= cycCnt + 5'd1;
        o_hSync <= i_d0[0];
        o_vSync <= i_d0[1];
        hdrSr   <= hdrSrNxt;
        hdrC    <= hdrCNxt;
        hdrOk   <= hdrOkNxt;
        spOk    <= spOkNxt;
        for (int k = 0; k < 4; k++) begin
          spSr[k] <= spSrNxt[k];
          spC[k]  <= spCNxt[k];
        end
        if (latch) pktIdx <= pktIdx + IDXW'(1);
      end

      o_pkt_valid   <= latch;
      o_acr_valid   <= latch && isAcr;
      o_audio_valid <= selHit;
      pendMask      <= srcMask & ~selBit;
      o_parity_err  <= o_parity_err | (latch && |(cand & parBad));

      if (latch) begin
        o_pkt_hdr    <= hdrSr;
        o_hdr_ecc_ok <= hdrOkNxt;
        o_sp_ecc_ok  <= spOkNxt;
        holdB        <= hdrSr[23:20];
        for (int k = 0; k < 4; k++) begin
          holdL[k]  <= newL[k];
          holdR[k]  <= newR[k];
          holdCs[k] <= newCs[k];
        end
        if (isAcr) begin
          o_cts <= {spSr[0][11:8], spSr[0][23:16], spSr[0][31:24]};
          o_n   <= {spSr[0][35:32], spSr[0][47:40], spSr[0][55:48]};
        end
      end

      if (selHit) begin
        o_audioL      <= srcL;
        o_audioR      <= srcR;
        o_cs_bit      <= srcCs;
        o_block_start <= srcB;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
// Directed bench for hdmi_data_island_decoder: encodes packets with BCH parity,
// records output pulses on the falling edge and checks them per scenario.
module tb_hdmi_data_island_decoder;

  // clock / reset
  logic        i_pixclk = 1'b0;
  logic        i_reset  = 1'b1;
  logic        i_data   = 1'b0;
  logic [3:0]  i_d0 = '0, i_d1 = '0, i_d2 = '0;
  logic        o_hSync, o_vSync, o_pkt_valid, o_hdr_ecc_ok, o_acr_valid;
  logic        o_audio_valid, o_block_start, o_parity_err;
  logic [23:0] o_pkt_hdr;
  logic [3:0]  o_sp_ecc_ok;
  logic [19:0] o_n, o_cts;
  logic [15:0] o_audioL, o_audioR;
  logic [1:0]  o_cs_bit;

  always #5 i_pixclk = ~i_pixclk;

  hdmi_data_island_decoder dut (
    .i_pixclk(i_pixclk), .i_reset(i_reset), .i_data(i_data),
    .i_d0(i_d0), .i_d1(i_d1), .i_d2(i_d2),
    .o_hSync(o_hSync), .o_vSync(o_vSync),
    .o_pkt_valid(o_pkt_valid), .o_pkt_hdr(o_pkt_hdr),
    .o_hdr_ecc_ok(o_hdr_ecc_ok), .o_sp_ecc_ok(o_sp_ecc_ok),
    .o_acr_valid(o_acr_valid), .o_n(o_n), .o_cts(o_cts),
    .o_audio_valid(o_audio_valid), .o_audioL(o_audioL), .o_audioR(o_audioR),
    .o_block_start(o_block_start), .o_cs_bit(o_cs_bit), .o_parity_err(o_parity_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tick  = 0;

  typedef struct { int t; logic [23:0] hdr; logic hok; logic [3:0] spok; } pkt_ev_t;
  typedef struct { int t; logic [34:0] smp; } aud_ev_t;
  pkt_ev_t     pkt_q[$];
  aud_ev_t     aud_q[$];
  int          acr_q[$];
  logic [34:0] exp_q[$];

  logic [23:0] hflip = '0;
  logic [55:0] sflip [4];
  logic [1:0]  sync_pat = '0;
  logic [55:0] aud_s0, aud_s1, acr_sp, info_sp;

  // event recorder
  always @(negedge i_pixclk) begin
    pkt_ev_t pe;
    aud_ev_t ae;
    tick = tick + 1;
    if (!i_reset) begin
      if (o_pkt_valid) begin
        pe.t = tick; pe.hdr = o_pkt_hdr; pe.hok = o_hdr_ecc_ok; pe.spok = o_sp_ecc_ok;
        pkt_q.push_back(pe);
      end
      if (o_audio_valid) begin
        ae.t = tick; ae.smp = {o_block_start, o_cs_bit, o_audioL, o_audioR};
        aud_q.push_back(ae);
      end
      if (o_acr_valid) acr_q.push_back(tick);
    end
  end

  function automatic logic [7:0] bch_calc(input logic [55:0] bits, input int nbits);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < nbits; i++)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 8'hC1 : 8'h00);
    return c;
  endfunction

  function automatic logic [55:0] make_acr_sp(input logic [19:0] n, input logic [19:0] cts);
    logic [55:0] sp = '0;
    sp[11:8]  = cts[19:16];
    sp[23:16] = cts[15:8];
    sp[31:24] = cts[7:0];
    sp[35:32] = n[19:16];
    sp[47:40] = n[15:8];
    sp[55:48] = n[7:0];
    return sp;
  endfunction

  function automatic logic [55:0] make_aud_sp(input logic [15:0] l, input logic [15:0] r,
                                              input logic cs_l, input logic cs_r);
    logic [55:0] sp = '0;
    sp[23:8]  = l;
    sp[47:32] = r;
    sp[50]    = cs_l;
    sp[54]    = cs_r;
    sp[27]    = ^sp[26:0];
    sp[51]    = ^{sp[50:48], sp[47:24]};
    return sp;
  endfunction

  // driver tasks
  task automatic send_packet(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                             input logic [55:0] s2, input logic [55:0] s3, input int ncyc);
    logic [55:0] s [4];
    logic [55:0] sx [4];
    logic [7:0]  p [4];
    logic [7:0]  hp;
    logic [23:0] hx;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    hp = bch_calc({32'h0, h}, 24);
    hx = h ^ hflip;
    for (int k = 0; k < 4; k++) begin
      p[k]  = bch_calc(s[k], 56);
      sx[k] = s[k] ^ sflip[k];
    end
    for (int n = 0; n < ncyc; n++) begin
      @(negedge i_pixclk);
      i_data     = 1'b1;
      i_d0[1:0]  = sync_pat;
      i_d0[3]    = (n != 0);
      i_d0[2]    = (n < 24) ? hx[n] : hp[7-(n-24)];
      for (int k = 0; k < 4; k++) begin
        if (n < 28) begin
          i_d1[k] = sx[k][2*n];
          i_d2[k] = sx[k][2*n+1];
        end else begin
          i_d1[k] = p[k][7-2*(n-28)];
          i_d2[k] = p[k][6-2*(n-28)];
        end
      end
    end
  endtask

  task automatic idle(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge i_pixclk);
      i_data = 1'b0; i_d0 = '0; i_d1 = '0; i_d2 = '0;
    end
  endtask

  task automatic clear_q();
    pkt_q.delete(); aud_q.delete(); acr_q.delete(); exp_q.delete();
    hflip = '0;
    for (int k = 0; k < 4; k++) sflip[k] = '0;
  endtask

  // scenarios
  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge i_pixclk);
    n_cmp++;
    if ({o_hSync, o_vSync, o_pkt_valid, o_pkt_hdr, o_hdr_ecc_ok, o_sp_ecc_ok, o_acr_valid, o_n,
         o_cts, o_audio_valid, o_audioL, o_audioR, o_block_start, o_cs_bit, o_parity_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero output while in reset (n=%h cts=%h hdr=%h)",
                        o_n, o_cts, o_pkt_hdr);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_acr();
    clear_q();
    send_packet(24'h000001, acr_sp, acr_sp, acr_sp, acr_sp, 32);
    idle(6);
    n_cmp++;
    if (pkt_q.size() != 1 || acr_q.size() != 1) begin
      n_bad++; $display("FAIL acr_pulses: got pkt=%0d acr=%0d expected 1/1", pkt_q.size(), acr_q.size());
    end else begin
      n_cmp++;
      if (pkt_q[0].hdr !== 24'h000001 || pkt_q[0].hok !== 1'b1 || pkt_q[0].spok !== 4'hF) begin
        n_bad++; $display("FAIL acr_hdr: got hdr=%h hok=%b spok=%h expected 000001/1/f",
                          pkt_q[0].hdr, pkt_q[0].hok, pkt_q[0].spok);
      end
      n_cmp++;
      if (acr_q[0] != pkt_q[0].t) begin
        n_bad++; $display("FAIL acr_timing: got acr at %0d expected %0d", acr_q[0], pkt_q[0].t);
      end
    end
    n_cmp++;
    if (o_n !== 20'd6144 || o_cts !== 20'd27000) begin
      n_bad++; $display("FAIL acr_n_cts: got n=%0d cts=%0d expected 6144/27000", o_n, o_cts);
    end
  endtask

  task automatic test_audio();
    aud_ev_t ev;
    logic [34:0] e;
    clear_q();
    exp_q.push_back({1'b1, 2'b10, 16'h1234, 16'hABCD});
    exp_q.push_back({1'b0, 2'b01, 16'h0001, 16'h8000});
    send_packet(24'h100302, aud_s0, aud_s1, 56'h0, 56'h0, 32);
    idle(8);
    n_cmp++;
    if (pkt_q.size() != 1 || aud_q.size() != 2) begin
      n_bad++; $display("FAIL audio_count: got pkt=%0d aud=%0d expected 1/2", pkt_q.size(), aud_q.size());
    end else begin
      n_cmp++;
      if (aud_q[0].t != pkt_q[0].t || aud_q[1].t != pkt_q[0].t + 1) begin
        n_bad++; $display("FAIL audio_timing: got %0d,%0d expected %0d,%0d",
                          aud_q[0].t, aud_q[1].t, pkt_q[0].t, pkt_q[0].t + 1);
      end
    end
    while (exp_q.size() > 0 && aud_q.size() > 0) begin
      e = exp_q.pop_front(); ev = aud_q.pop_front();
      n_cmp++;
      if (ev.smp !== e) begin
        n_bad++; $display("FAIL audio_sample: got %h expected %h", ev.smp, e);
      end
    end
    n_cmp++;
    if (o_parity_err !== 1'b0 || acr_q.size() != 0) begin
      n_bad++; $display("FAIL audio_side: got perr=%b acr=%0d expected 0/0", o_parity_err, acr_q.size());
    end
  endtask

  task automatic test_hdr_error();
    clear_q();
    hflip = 24'h000200;
    send_packet(24'h100302, aud_s0, aud_s1, 56'h0, 56'h0, 32);
    idle(8);
    n_cmp++;
    if (pkt_q.size() != 1) begin
      n_bad++; $display("FAIL hdrerr_pkt: got %0d pulses expected 1", pkt_q.size());
    end else begin
      n_cmp++;
      if (pkt_q[0].hdr !== 24'h100102 || pkt_q[0].hok !== 1'b0 || pkt_q[0].spok !== 4'hF) begin
        n_bad++; $display("FAIL hdrerr_flags: got hdr=%h hok=%b spok=%h expected 100102/0/f",
                          pkt_q[0].hdr, pkt_q[0].hok, pkt_q[0].spok);
      end
    end
    n_cmp++;
    if (aud_q.size() != 0) begin
      n_bad++; $display("FAIL hdrerr_audio: got %0d samples expected 0", aud_q.size());
    end
  endtask

  task automatic test_sp_error();
    aud_ev_t ev;
    clear_q();
    sflip[1] = 56'h1 << 10;
    exp_q.push_back({1'b1, 2'b10, 16'h1234, 16'hABCD});
    send_packet(24'h100302, aud_s0, aud_s1, 56'h0, 56'h0, 32);
    idle(8);
    n_cmp++;
    if (pkt_q.size() != 1 || aud_q.size() != 1) begin
      n_bad++; $display("FAIL sperr_count: got pkt=%0d aud=%0d expected 1/1", pkt_q.size(), aud_q.size());
    end else begin
      n_cmp++;
      if (pkt_q[0].spok !== 4'b1101 || pkt_q[0].hok !== 1'b1) begin
        n_bad++; $display("FAIL sperr_flags: got spok=%b hok=%b expected 1101/1", pkt_q[0].spok, pkt_q[0].hok);
      end
      ev = aud_q.pop_front();
      n_cmp++;
      if (ev.smp !== exp_q[0]) begin
        n_bad++; $display("FAIL sperr_sample: got %h expected %h", ev.smp, exp_q[0]);
      end
    end
  endtask

  task automatic test_parity();
    aud_ev_t ev;
    clear_q();
    exp_q.push_back({1'b0, 2'b01, 16'h0001, 16'h8000});
    send_packet(24'h100302, aud_s0 ^ (56'h1 << 51), aud_s1, 56'h0, 56'h0, 32);
    idle(8);
    n_cmp++;
    if (pkt_q.size() != 1 || aud_q.size() != 1) begin
      n_bad++; $display("FAIL parity_count: got pkt=%0d aud=%0d expected 1/1", pkt_q.size(), aud_q.size());
    end else begin
      ev = aud_q.pop_front();
      n_cmp++;
      if (ev.smp !== exp_q[0] || ev.t != pkt_q[0].t || pkt_q[0].spok !== 4'hF) begin
        n_bad++; $display("FAIL parity_sample: got %h at %0d spok=%h expected %h at %0d spok=f",
                          ev.smp, ev.t, pkt_q[0].spok, exp_q[0], pkt_q[0].t);
      end
    end
    n_cmp++;
    if (o_parity_err !== 1'b1) begin
      n_bad++; $display("FAIL parity_err_set: got %b expected 1", o_parity_err);
    end
    send_packet(24'h100302, aud_s0, aud_s1, 56'h0, 56'h0, 32);
    idle(8);
    n_cmp++;
    if (o_parity_err !== 1'b1) begin
      n_bad++; $display("FAIL parity_err_sticky: got %b expected 1", o_parity_err);
    end
    i_reset = 1'b1;
    repeat (2) @(negedge i_pixclk);
    i_reset = 1'b0;
    @(negedge i_pixclk);
    n_cmp++;
    if (o_parity_err !== 1'b0) begin
      n_bad++; $display("FAIL parity_err_reset: got %b expected 0", o_parity_err);
    end
  endtask

  task automatic test_abort_island();
    clear_q();
    sync_pat = 2'b11;
    send_packet(24'h000001, acr_sp, acr_sp, acr_sp, acr_sp, 15);
    idle(40);
    n_cmp++;
    if (pkt_q.size() != 0 || acr_q.size() != 0 || aud_q.size() != 0) begin
      n_bad++; $display("FAIL abort_pulses: got pkt=%0d acr=%0d aud=%0d expected 0/0/0",
                        pkt_q.size(), acr_q.size(), aud_q.size());
    end
    n_cmp++;
    if ({o_vSync, o_hSync} !== 2'b11 || o_n !== 20'd0) begin
      n_bad++; $display("FAIL abort_state: got sync=%b n=%0d expected 11/0", {o_vSync, o_hSync}, o_n);
    end
    sync_pat = 2'b10;
    send_packet(24'h0D0282, info_sp, info_sp, info_sp, info_sp, 32);
    @(posedge i_pixclk); #1;
    n_cmp++;
    if ({o_vSync, o_hSync} !== 2'b10) begin
      n_bad++; $display("FAIL sync_track_a: got %b expected 10", {o_vSync, o_hSync});
    end
    sync_pat = 2'b01;
    send_packet(24'h100302, aud_s0, aud_s1, 56'h0, 56'h0, 32);
    idle(8);
    n_cmp++;
    if ({o_vSync, o_hSync} !== 2'b01) begin
      n_bad++; $display("FAIL sync_track_b: got %b expected 01", {o_vSync, o_hSync});
    end
    n_cmp++;
    if (pkt_q.size() != 2 || aud_q.size() != 2 || acr_q.size() != 0) begin
      n_bad++; $display("FAIL island_count: got pkt=%0d aud=%0d acr=%0d expected 2/2/0",
                        pkt_q.size(), aud_q.size(), acr_q.size());
    end else begin
      n_cmp++;
      if (pkt_q[1].t - pkt_q[0].t != 32) begin
        n_bad++; $display("FAIL island_spacing: got %0d expected 32", pkt_q[1].t - pkt_q[0].t);
      end
      n_cmp++;
      if (pkt_q[0].hdr !== 24'h0D0282 || pkt_q[1].hdr !== 24'h100302) begin
        n_bad++; $display("FAIL island_hdrs: got %h,%h expected 0d0282,100302", pkt_q[0].hdr, pkt_q[1].hdr);
      end
      n_cmp++;
      if (aud_q[0].smp !== {1'b1, 2'b10, 16'h1234, 16'hABCD} || aud_q[1].t != pkt_q[1].t + 1) begin
        n_bad++; $display("FAIL island_audio: got %h at %0d", aud_q[0].smp, aud_q[1].t);
      end
    end
    sync_pat = 2'b00;
  endtask

  task automatic test_max_packets();
    clear_q();
    for (int i = 0; i < 18; i++) send_packet(24'h0D0282, info_sp, info_sp, info_sp, info_sp, 32);
    send_packet(24'h000001, make_acr_sp(20'd1234, 20'd5678), 56'h0, 56'h0, 56'h0, 32);
    idle(6);
    n_cmp++;
    if (pkt_q.size() != 18 || acr_q.size() != 0) begin
      n_bad++; $display("FAIL max_pkts: got pkt=%0d acr=%0d expected 18/0", pkt_q.size(), acr_q.size());
    end
    n_cmp++;
    if (o_n !== 20'd0 || o_cts !== 20'd0) begin
      n_bad++; $display("FAIL max_n_kept: got n=%0d cts=%0d expected 0/0", o_n, o_cts);
    end
    clear_q();
    send_packet(24'h000001, make_acr_sp(20'd1234, 20'd5678), 56'h0, 56'h0, 56'h0, 32);
    idle(6);
    n_cmp++;
    if (acr_q.size() != 1 || o_n !== 20'd1234 || o_cts !== 20'd5678) begin
      n_bad++; $display("FAIL new_island_acr: got acr=%0d n=%0d cts=%0d expected 1/1234/5678",
                        acr_q.size(), o_n, o_cts);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) sflip[k] = '0;
    aud_s0  = make_aud_sp(16'h1234, 16'hABCD, 1'b0, 1'b1);
    aud_s1  = make_aud_sp(16'h0001, 16'h8000, 1'b1, 1'b0);
    acr_sp  = make_acr_sp(20'd6144, 20'd27000);
    info_sp = 56'h00_1122_3344_5566;
    test_reset();
    idle(2);
    test_acr();
    test_audio();
    test_hdr_error();
    test_sp_error();
    test_parity();
    test_abort_island();
    test_max_packets();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
